adder_i12_o7_sync: RTL and testbench



---
 rtl/adder_i12_o7_sync.sv | 55 +++++
 tb/tb_adder_i12_o7_sync.sv | 130 +++++++++++++
 2 files changed

// File: rtl/adder_i12_o7_sync.sv
`default_nettype none
// ============================================================================
// Module   : adder_i12_o7_sync
// Brief    : Exact registered 6+6-bit ripple-carry adder, flat 12-in/7-out.
// Revision : 1.0 - initial release
// ============================================================================
module adder_i12_o7_sync (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] pi,
    output logic [6:0]  po,
    output logic        out_valid
);

    localparam int unsigned C_NBITS = 6;

    logic [C_NBITS-1:0] w_a;
    logic [C_NBITS-1:0] w_b;
    logic [C_NBITS-1:0] w_s;
    logic [C_NBITS:0]   w_c;
    logic [6:0]         w_sum;

    logic [6:0]         r_po;
    logic               r_out_valid;

    assign w_a    = pi[5:0];
    assign w_b    = pi[11:6];
    assign w_c[0] = 1'b0;

    // Explicit full-adder cells so the golden reference has a defined carry chain.
    for (genvar gi = 0; gi < C_NBITS; gi++) begin : g_fa
        assign w_s[gi]   = w_a[gi] ^ w_b[gi] ^ w_c[gi];
        assign w_c[gi+1] = (w_a[gi] & w_b[gi]) | (w_a[gi] & w_c[gi]) | (w_b[gi] & w_c[gi]);
    end

    assign w_sum = {w_c[C_NBITS], w_s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_po        <= 7'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_po <= w_sum;
            end
        end
    end

    assign po        = r_po;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_i12_o7_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_i12_o7_sync
// Brief    : Scoreboard bench for adder_i12_o7_sync (directed, exhaustive, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_i12_o7_sync;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] pi;
    logic [6:0]  po;
    logic        out_valid;

    int unsigned n_vec;
    int unsigned n_err;

    logic [6:0]  sb_q[$];
    logic        exp_valid;
    logic [6:0]  exp_po;

    adder_i12_o7_sync u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pi        (pi),
        .po        (po),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, update the reference model, then check after the edge.
    task automatic apply(input logic rst_i, input logic vld_i, input logic [11:0] p_i);
        logic [6:0] w_exp;
        rst_n    = rst_i;
        in_valid = vld_i;
        pi       = p_i;
        if (!rst_i) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_po    = 7'd0;
        end else if (vld_i) begin
            sb_q.push_back(7'({1'b0, p_i[5:0]} + {1'b0, p_i[11:6]}));
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid === 1'b1) begin
            chk("sb_size", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                w_exp  = sb_q.pop_front();
                exp_po = w_exp;
                chk("po_sum", 32'(po), 32'(w_exp));
            end
        end else begin
            chk("po_hold", 32'(po), 32'(exp_po));
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_valid = 1'b0;
        exp_po    = 7'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        pi        = 12'd0;

        // Reset held for two edges with a valid all-ones input
        apply(1'b0, 1'b1, 12'hFFF);
        apply(1'b0, 1'b1, 12'hFFF);

        // Directed sums, extremes and full carry ripple, with literal expectations
        apply(1'b1, 1'b1, 12'b000101000100);
        chk("dir_9", 32'(po), 32'd9);
        apply(1'b1, 1'b1, 12'b010011100000);
        chk("dir_51", 32'(po), 32'd51);
        apply(1'b1, 1'b1, 12'b101111011001);
        chk("dir_72", 32'(po), 32'd72);
        apply(1'b1, 1'b1, 12'b000000000000);
        chk("ext_0", 32'(po), 32'd0);
        apply(1'b1, 1'b1, 12'b111111111111);
        chk("ext_126", 32'(po), 32'd126);
        apply(1'b1, 1'b1, 12'b110111111111);
        chk("ext_118", 32'(po), 32'd118);
        apply(1'b1, 1'b1, 12'b000001111111);
        chk("carry_64", 32'(po), 32'd64);

        // Valid gating: result must hold while in_valid is low
        apply(1'b1, 1'b1, 12'b000101000100);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, 12'hFFF);
            chk("gate_hold", 32'(po), 32'd9);
        end

        // Exhaustive back-to-back sweep
        for (int v = 0; v < 4096; v++) begin
            apply(1'b1, 1'b1, 12'(v));
        end

        // Random traffic with a one-cycle reset in the middle
        for (int r = 0; r < 100; r++) begin
            if (r == 50) begin
                apply(1'b0, 1'b1, 12'($urandom_range(0, 4095)));
                chk("mid_rst_po", 32'(po), 32'd0);
            end else begin
                apply(1'b1, 1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
